// File: rtl/uart_block_assembler_if.sv
// Byte-in / block-out bus between the UART receiver, the block assembler and the AES core.
interface uart_block_assembler_if;
  logic         i_fByteValid;
  logic [7:0]   i_Byte;
  logic [127:0] o_Block;
  logic         o_fBlockValid;
  logic         i_fBlockReady;
  logic [4:0]   o_ByteCnt;
  logic         o_fOverflow;
  logic         o_fTimeout;

  // Assembler side.
  modport slave (
    input  i_fByteValid, i_Byte, i_fBlockReady,
    output o_Block, o_fBlockValid, o_ByteCnt, o_fOverflow, o_fTimeout
  );

  // Byte producer / block consumer side.
  modport master (
    output i_fByteValid, i_Byte, i_fBlockReady,
    input  o_Block, o_fBlockValid, o_ByteCnt, o_fOverflow, o_fTimeout
  );
endinterface

// File: rtl/uart_block_assembler.sv
// Packs received UART bytes into 128-bit blocks for the AES core, discarding
// partial blocks after inter-byte silence and dropping bytes while a block waits.
module uart_block_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 43400
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  uart_block_assembler_if.slave bus
);

  localparam int unsigned BLOCK_W   = 128;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned TIMER_W   = 16;
  localparam int unsigned BLOCK_LEN = 16;

  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(BLOCK_LEN - 1);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t               state_q, state_d;
  logic [BLOCK_W-1:0]   block_q, block_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q,   ovf_d;
  logic                 tmo_q,   tmo_d;

  // State and datapath registers.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= IDLE;
      block_q <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      block_q <= block_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    block_d = block_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    ovf_d   = 1'b0;
    tmo_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.i_fByteValid) begin
          block_d = {block_q[BLOCK_W-9:0], bus.i_Byte};
          cnt_d   = cnt_q + CNT_W'(1);
          timer_d = '0;
          state_d = FILL;
        end
      end

      FILL: begin
        // An arriving byte always beats the timeout in the same cycle.
        if (bus.i_fByteValid) begin
          block_d = {block_q[BLOCK_W-9:0], bus.i_Byte};
          cnt_d   = cnt_q + CNT_W'(1);
          timer_d = '0;
          if (cnt_q == CNT_LAST) state_d = FULL;
        end else if (timer_q == TIMEOUT_LAST) begin
          block_d = '0;
          cnt_d   = '0;
          timer_d = '0;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      FULL: begin
        timer_d = '0;
        if (bus.i_fBlockReady) begin
          if (bus.i_fByteValid) begin
            block_d = {{(BLOCK_W-8){1'b0}}, bus.i_Byte};
            cnt_d   = CNT_W'(1);
            state_d = FILL;
          end else begin
            block_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else if (bus.i_fByteValid) begin
          ovf_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        block_d = '0;
        cnt_d   = '0;
        timer_d = '0;
      end
    endcase

    valid_d = (state_d == FULL);
  end

  assign bus.o_Block       = block_q;
  assign bus.o_fBlockValid = valid_q;
  assign bus.o_ByteCnt     = cnt_q;
  assign bus.o_fOverflow   = ovf_q;
  assign bus.o_fTimeout    = tmo_q;

endmodule

// File: tb/tb_uart_block_assembler.sv
// Scoreboard bench for uart_block_assembler with a short timeout.
module tb_uart_block_assembler;

  localparam int unsigned TMO = 100;

  logic i_Clk = 1'b0;
  logic i_Rst;

  uart_block_assembler_if bus();

  uart_block_assembler #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .bus   (bus)
  );

  always #5 i_Clk = ~i_Clk;

  int checks   = 0;
  int failures = 0;
  int tmo_seen = 0;

  logic [127:0] exp_q[$];
  logic [127:0] mdl_blk;
  int           mdl_cnt;
  logic         exp_ovf;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Block consumer monitor: the handshake edge follows this sample.
  always @(negedge i_Clk) begin
    if (bus.o_fTimeout === 1'b1) tmo_seen++;
    if (i_Rst && bus.o_fBlockValid === 1'b1 && bus.i_fBlockReady === 1'b1) begin
      if (exp_q.size() == 0) check("sb_unexpected_block", bus.o_Block, '0);
      else                   check("sb_block", bus.o_Block, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic mdl_clear();
    mdl_blk = '0;
    mdl_cnt = 0;
  endtask

  // Drive one byte pulse, advance the reference model, check count and overflow.
  task automatic send_byte(input logic [7:0] b);
    exp_ovf = 1'b0;
    if (mdl_cnt == 16) begin
      if (bus.i_fBlockReady) begin
        mdl_blk = {120'b0, b};
        mdl_cnt = 1;
      end else begin
        exp_ovf = 1'b1;
      end
    end else begin
      mdl_blk = {mdl_blk[119:0], b};
      mdl_cnt++;
      if (mdl_cnt == 16) exp_q.push_back(mdl_blk);
    end
    bus.i_fByteValid = 1'b1;
    bus.i_Byte       = b;
    tick();
    bus.i_fByteValid = 1'b0;
    check("byte_cnt", 128'(bus.o_ByteCnt), 128'(mdl_cnt));
    check("overflow", 128'(bus.o_fOverflow), 128'(exp_ovf));
    check("block_valid", 128'(bus.o_fBlockValid), 128'(mdl_cnt == 16));
  endtask

  task automatic consume();
    bus.i_fBlockReady = 1'b1;
    tick();
    bus.i_fBlockReady = 1'b0;
    mdl_clear();
    check("post_consume_valid", 128'(bus.o_fBlockValid), 128'(0));
    check("post_consume_cnt", 128'(bus.o_ByteCnt), 128'(0));
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      idle($urandom_range(0, 30));
      send_byte(8'($urandom));
    end
  endtask

  // Bounded wait for the timeout pulse; returns cycles after the last accept edge.
  task automatic wait_timeout(output int n);
    n = 0;
    while (n <= 2 * TMO) begin
      tick();
      n++;
      if (bus.o_fTimeout === 1'b1) break;
    end
  endtask

  initial begin
    int n;
    int tmo_before;
    i_Rst = 1'b0;
    bus.i_fByteValid = 1'b0;
    bus.i_Byte = '0;
    bus.i_fBlockReady = 1'b0;
    mdl_clear();

    // Reset held with random inputs.
    for (int i = 0; i < 8; i++) begin
      @(posedge i_Clk);
      #1;
      bus.i_fByteValid  = 1'($urandom);
      bus.i_Byte        = 8'($urandom);
      bus.i_fBlockReady = 1'($urandom);
      @(negedge i_Clk);
      check("rst_block", bus.o_Block, '0);
      check("rst_flags", 128'({bus.o_fBlockValid, bus.o_ByteCnt, bus.o_fOverflow, bus.o_fTimeout}), '0);
    end
    bus.i_fByteValid = 1'b0;
    bus.i_fBlockReady = 1'b0;
    tick();
    i_Rst = 1'b1;
    tick();

    // Full block of 0x00..0x0F, held while the consumer is not ready.
    for (int i = 0; i < 16; i++) begin
      idle($urandom_range(0, 40));
      send_byte(8'(i));
    end
    check("full_block", bus.o_Block, 128'h000102030405060708090A0B0C0D0E0F);
    idle(1000);
    check("hold_valid", 128'(bus.o_fBlockValid), 128'(1));
    check("hold_block", bus.o_Block, 128'h000102030405060708090A0B0C0D0E0F);
    check("hold_cnt", 128'(bus.o_ByteCnt), 128'(16));
    check("hold_no_timeout", 128'(tmo_seen), 128'(0));
    consume();

    // Overflow while full.
    fill_random();
    send_byte(8'hAA);
    check("ovf_block", bus.o_Block, mdl_blk);
    tick();
    check("ovf_fall", 128'(bus.o_fOverflow), 128'(0));
    check("ovf_cnt_after", 128'(bus.o_ByteCnt), 128'(16));

    // Consume and first byte of the next block in the same cycle.
    bus.i_fBlockReady = 1'b1;
    send_byte(8'h55);
    bus.i_fBlockReady = 1'b0;
    for (int i = 1; i < 16; i++) send_byte(8'(i));
    check("next_first_byte", 128'(bus.o_Block[127:120]), 128'(8'h55));
    consume();

    // Timeout after 5 bytes, then a clean block.
    tmo_before = tmo_seen;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    wait_timeout(n);
    check("tmo_latency", 128'(n), 128'(TMO));
    check("tmo_cnt", 128'(bus.o_ByteCnt), 128'(0));
    mdl_clear();
    tick();
    check("tmo_pulse_width", 128'(bus.o_fTimeout), 128'(0));
    check("tmo_pulse_count", 128'(tmo_seen - tmo_before), 128'(1));
    fill_random();
    consume();

    // Byte in the cycle where the timer reaches TMO-1 wins, and restarts the timer.
    tmo_before = tmo_seen;
    send_byte(8'h11);
    idle(TMO - 1);
    send_byte(8'h22);
    idle(TMO - 1);
    send_byte(8'h33);
    check("boundary_no_timeout", 128'(tmo_seen - tmo_before), 128'(0));
    check("boundary_cnt", 128'(bus.o_ByteCnt), 128'(3));
    wait_timeout(n);
    check("boundary_restart_latency", 128'(n), 128'(TMO));
    mdl_clear();
    tick();

    // Asynchronous reset mid-fill.
    for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(1, 255)));
    @(negedge i_Clk);
    #2;
    i_Rst = 1'b0;
    #1;
    check("async_rst_cnt", 128'(bus.o_ByteCnt), 128'(0));
    check("async_rst_block", bus.o_Block, '0);
    mdl_clear();
    tick();
    i_Rst = 1'b1;
    tick();
    send_byte(8'h77);

    check("sb_leftover", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
